aes_decrypt_engine: RTL and testbench

Iterative AES-128 decryption core, the inverse counterpart of the team's AES encryption engine.
- Expands a 128-bit key once and stores all 11 round keys.
- Then decrypts one 128-bit ciphertext block at a time, one inverse round per clock.
- Sits on the receive side of the crypto datapath and uses the same valid/ready naming as the encrypt side.

---
 rtl/aes_decrypt_engine.sv | 233 +++++++++++++++++++++++
 tb/tb_aes_decrypt_engine.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_engine.sv
// Iterative AES-128 decryption core: stores all 11 round keys, then runs one inverse round per clock.
// Optional macro AES_DEC_DROP_DETECT_EN adds a sticky 'hata' flag for requests dropped while busy.

// GF(2^8) multiplicative inverse (0 maps to 0), computed as a^254.
module aes_gf_inv (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    assign y = gf_inv(a);
endmodule

// Forward S-box, needed only by the key schedule.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] b;

    aes_gf_inv u_inv (.a(a), .y(b));

    assign y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform followed by the field inverse.
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] t;

    assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

    aes_gf_inv u_inv (.a(t), .y(y));
endmodule

module aes_decrypt_engine #(
    parameter int NR       = 10,
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_BITS-1:0] anahtar,
    input  logic                anahtar_gecerli,
    input  logic [127:0]        sifre,
    input  logic                g_gecerli,
    output logic                hazir,
    output logic [127:0]        blok,
    output logic                c_gecerli
`ifdef AES_DEC_DROP_DETECT_EN
    ,
    output logic                hata
`endif
);
    localparam logic [1:0] S_NOKEY  = 2'd0;
    localparam logic [1:0] S_KEYEXP = 2'd1;
    localparam logic [1:0] S_READY  = 2'd2;
    localparam logic [1:0] S_ROUND  = 2'd3;

    localparam logic [3:0] LAST_RK  = 4'(NR);
    localparam logic [3:0] FIRST_RD = 4'(NR - 1);

    logic [1:0]   state;
    logic [3:0]   cnt;
    logic [127:0] st;
    logic [127:0] rk [0:NR];

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] i);
        case (i)
            4'd1:    rcon_of = 8'h01;
            4'd2:    rcon_of = 8'h02;
            4'd3:    rcon_of = 8'h04;
            4'd4:    rcon_of = 8'h08;
            4'd5:    rcon_of = 8'h10;
            4'd6:    rcon_of = 8'h20;
            4'd7:    rcon_of = 8'h40;
            4'd8:    rcon_of = 8'h80;
            4'd9:    rcon_of = 8'h1b;
            4'd10:   rcon_of = 8'h36;
            default: rcon_of = 8'h00;
        endcase
    endfunction

    // Forward key schedule: derives rk[cnt] from rk[cnt-1].
    logic [127:0] kprev;
    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [31:0]  t_w;
    logic [31:0]  w4, w5, w6, w7;
    logic [127:0] knext;

    assign kprev = rk[cnt - 4'd1];
    assign rot_w = {kprev[23:0], kprev[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_ksub
        aes_sbox u_sbox (.a(rot_w[8*i +: 8]), .y(sub_w[8*i +: 8]));
    end

    assign t_w   = sub_w ^ {rcon_of(cnt), 24'h000000};
    assign w4    = kprev[127:96] ^ t_w;
    assign w5    = kprev[95:64]  ^ w4;
    assign w6    = kprev[63:32]  ^ w5;
    assign w7    = kprev[31:0]   ^ w6;
    assign knext = {w4, w5, w6, w7};

    // Inverse round: InvShiftRows (row r rotated right by r), InvSubBytes, AddRoundKey, InvMixColumns.
    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] ark;
    logic [127:0] imc;
    logic [127:0] rnd_out;

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shifted[127-8*(4*c+r) -: 8] = st[127-8*(4*((c+4-r)%4)+r) -: 8];
            aes_inv_sbox u_isbox (
                .a(shifted[127-8*(4*c+r) -: 8]),
                .y(subbed[127-8*(4*c+r) -: 8])
            );
        end
    end

    assign ark = subbed ^ rk[cnt];

    for (genvar c = 0; c < 4; c++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark[127-8*(4*c+0) -: 8];
        assign a1 = ark[127-8*(4*c+1) -: 8];
        assign a2 = ark[127-8*(4*c+2) -: 8];
        assign a3 = ark[127-8*(4*c+3) -: 8];
        assign imc[127-8*(4*c+0) -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        assign imc[127-8*(4*c+1) -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        assign imc[127-8*(4*c+2) -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        assign imc[127-8*(4*c+3) -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end

    assign rnd_out = (cnt == 4'd0) ? ark : imc;

    // A key request in READY wins over a concurrent block, so hazir drops combinationally.
    assign hazir = (state == S_READY) && !anahtar_gecerli;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_NOKEY;
            cnt       <= 4'd0;
            st        <= '0;
            blok      <= '0;
            c_gecerli <= 1'b0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else begin
            c_gecerli <= 1'b0;
            case (state)
                S_NOKEY: begin
                    if (anahtar_gecerli) begin
                        rk[0] <= anahtar;
                        cnt   <= 4'd1;
                        state <= S_KEYEXP;
                    end
                end
                S_KEYEXP: begin
                    rk[cnt] <= knext;
                    if (cnt == LAST_RK) state <= S_READY;
                    else                cnt   <= cnt + 4'd1;
                end
                S_READY: begin
                    if (anahtar_gecerli) begin
                        rk[0] <= anahtar;
                        cnt   <= 4'd1;
                        state <= S_KEYEXP;
                    end else if (g_gecerli) begin
                        st    <= sifre ^ rk[NR];
                        cnt   <= FIRST_RD;
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (cnt == 4'd0) begin
                        blok      <= rnd_out;
                        c_gecerli <= 1'b1;
                        state     <= S_READY;
                    end else begin
                        st  <= rnd_out;
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= S_NOKEY;
            endcase
        end
    end

`ifdef AES_DEC_DROP_DETECT_EN
    always_ff @(posedge clk) begin
        if (!rst)                                            hata <= 1'b0;
        else if (g_gecerli && !hazir && state != S_NOKEY)    hata <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_aes_decrypt_engine.sv
// Directed testbench for aes_decrypt_engine using FIPS-197 vectors and timing checks.
// Build with +define+AES_DEC_DROP_DETECT_EN to also check the sticky drop flag.
module tb_aes_decrypt_engine;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] anahtar = '0;
    logic         anahtar_gecerli = 1'b0;
    logic [127:0] sifre = '0;
    logic         g_gecerli = 1'b0;
    logic         hazir;
    logic [127:0] blok;
    logic         c_gecerli;
`ifdef AES_DEC_DROP_DETECT_EN
    logic         hata;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t0, at, n, zeros;
    logic seen_c, seen_h;

    aes_decrypt_engine dut (
        .clk             (clk),
        .rst             (rst),
        .anahtar         (anahtar),
        .anahtar_gecerli (anahtar_gecerli),
        .sifre           (sifre),
        .g_gecerli       (g_gecerli),
        .hazir           (hazir),
        .blok            (blok),
        .c_gecerli       (c_gecerli)
`ifdef AES_DEC_DROP_DETECT_EN
        ,
        .hata            (hata)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic kv, input logic [127:0] k, input logic gv, input logic [127:0] s);
        anahtar_gecerli = kv;
        anahtar         = k;
        g_gecerli       = gv;
        sifre           = s;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic waitPulse(output int when);
        int k;
        k = 0;
        while (!c_gecerli && k < 40) begin
            tick;
            k++;
        end
        when = cyc;
    endtask

    initial begin
        // Reset held for two edges
        applyStimulus(1'b0, '0, 1'b0, '0);
        rst = 1'b0;
        tick;
        tick;
        checkOutput("rst_hazir", 128'(hazir), 128'd0);
        checkOutput("rst_cvalid", 128'(c_gecerli), 128'd0);
        checkOutput("rst_blok", blok, 128'd0);

        // NOKEY ignores blocks
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, C1);
        tick;
        tick;
        checkOutput("nokey_hazir", 128'(hazir), 128'd0);
        checkOutput("nokey_cvalid", 128'(c_gecerli), 128'd0);
`ifdef AES_DEC_DROP_DETECT_EN
        checkOutput("nokey_hata", 128'(hata), 128'd0);
`endif

        // Key load: hazir low for exactly 10 cycles
        applyStimulus(1'b1, K1, 1'b0, '0);
        tick;
        applyStimulus(1'b0, K1, 1'b0, '0);
        zeros = 0;
        while (!hazir && zeros < 30) begin
            zeros++;
            tick;
        end
        checkOutput("keyexp_len", 128'(zeros), 128'd10);
        checkOutput("ready_hazir", 128'(hazir), 128'd1);

        // FIPS-197 C.1
        applyStimulus(1'b0, K1, 1'b1, C1);
        tick;
        t0 = cyc;
        applyStimulus(1'b0, K1, 1'b0, '0);
        waitPulse(at);
        checkOutput("c1_latency", 128'(at - t0), 128'd10);
        checkOutput("c1_blok", blok, P1);
        tick;
        checkOutput("c1_pulse_width", 128'(c_gecerli), 128'd0);
        checkOutput("c1_hold", blok, P1);
`ifdef AES_DEC_DROP_DETECT_EN
        checkOutput("c1_hata", 128'(hata), 128'd0);
`endif

        // Key request and block together in READY: key wins, block dropped
        applyStimulus(1'b1, K1, 1'b1, C1);
        checkOutput("prio_hazir", 128'(hazir), 128'd0);
        tick;
        applyStimulus(1'b0, K1, 1'b0, '0);
        zeros  = 0;
        seen_c = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!hazir) zeros++;
            if (c_gecerli) seen_c = 1'b1;
            tick;
        end
        checkOutput("prio_busy_len", 128'(zeros), 128'd10);
        checkOutput("prio_no_output", 128'(seen_c), 128'd0);
`ifdef AES_DEC_DROP_DETECT_EN
        checkOutput("prio_hata", 128'(hata), 128'd1);
`endif

        // Key change with g_gecerli held high, back-to-back blocks
        applyStimulus(1'b1, K2, 1'b0, '0);
        tick;
        applyStimulus(1'b0, K2, 1'b1, C2);
        n = 0;
        while (!hazir && n < 30) begin
            tick;
            n++;
        end
        checkOutput("k2_ready", 128'(hazir), 128'd1);
        tick;
        t0 = cyc;
        applyStimulus(1'b0, K2, 1'b1, C1);
        waitPulse(at);
        checkOutput("b1_latency", 128'(at - t0), 128'd10);
        checkOutput("b1_blok", blok, P2);
        checkOutput("b2b_hazir", 128'(hazir), 128'd1);
        t0 = at;
        tick;
        waitPulse(at);
        checkOutput("b2b_spacing", 128'(at - t0), 128'd11);
        applyStimulus(1'b0, K2, 1'b0, '0);

        // Reset in the middle of a decryption
        applyStimulus(1'b0, K2, 1'b1, C2);
        tick;
        applyStimulus(1'b0, K2, 1'b0, '0);
        for (int i = 0; i < 4; i++) tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        checkOutput("mr_blok", blok, 128'd0);
`ifdef AES_DEC_DROP_DETECT_EN
        checkOutput("mr_hata", 128'(hata), 128'd0);
`endif
        seen_c = 1'b0;
        seen_h = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (c_gecerli) seen_c = 1'b1;
            if (hazir) seen_h = 1'b1;
            tick;
        end
        checkOutput("mr_no_output", 128'(seen_c), 128'd0);
        checkOutput("mr_no_hazir", 128'(seen_h), 128'd0);
        checkOutput("mr_blok_hold", blok, 128'd0);

        // Inputs pulsed during ROUND are ignored
        applyStimulus(1'b1, K1, 1'b0, '0);
        tick;
        applyStimulus(1'b0, K1, 1'b0, '0);
        n = 0;
        while (!hazir && n < 30) begin
            tick;
            n++;
        end
        applyStimulus(1'b0, K1, 1'b1, C1);
        tick;
        t0 = cyc;
        applyStimulus(1'b0, K1, 1'b0, '0);
        for (int i = 0; i < 3; i++) tick;
        applyStimulus(1'b1, K2, 1'b1, C2);
        tick;
        applyStimulus(1'b0, K2, 1'b0, '0);
        waitPulse(at);
        checkOutput("ign_latency", 128'(at - t0), 128'd10);
        checkOutput("ign_blok", blok, P1);
`ifdef AES_DEC_DROP_DETECT_EN
        checkOutput("ign_hata", 128'(hata), 128'd1);
`endif
        tick;
        checkOutput("ign_ready", 128'(hazir), 128'd1);
        seen_c = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (c_gecerli) seen_c = 1'b1;
            tick;
        end
        checkOutput("ign_no_extra", 128'(seen_c), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
